// File: rtl/dds_pkg.sv
// Shared types and constants for the DDS sweep controller and its dwell timer.
package dds_pkg;

    localparam int unsigned DDS_W = 12;

    typedef enum logic [2:0] {
        IDLE  = 3'd0,
        CLEAR = 3'd1,
        DWELL = 3'd2,
        STEP  = 3'd3,
        DONE  = 3'd4
    } sweep_state_t;

endpackage

// File: rtl/dds_dwell_timer.sv
// Dwell counter: load clears the count, run advances it, expire flags count == dwell.
// The expire flag is registered alongside the count so it always matches the held count.
module dds_dwell_timer #(
    parameter int unsigned DWELL_W = 16
) (
    input  logic               clk,
    input  logic               reset,
    input  logic               load_i,
    input  logic               run_i,
    input  logic [DWELL_W-1:0] dwell_i,
    output logic               expire_o
);

    logic [DWELL_W-1:0] cnt_q, cnt_d;
    logic               expire_q, expire_d;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            cnt_q    <= '0;
            expire_q <= 1'b0;
        end else begin
            cnt_q    <= cnt_d;
            expire_q <= expire_d;
        end
    end

    always_comb begin
        cnt_d = cnt_q;
        if (load_i) begin
            cnt_d = '0;
        end else if (run_i) begin
            cnt_d = cnt_q + DWELL_W'(1);
        end
        expire_d = (cnt_d == dwell_i);
    end

    assign expire_o = expire_q;

endmodule

// File: rtl/dds_sweep_ctrl.sv
// Frequency-sweep sequencer driving the DDS phase step (din) and accumulator clear.
// Optional DDS_SWEEP_TRIANGLE_EN adds an up/down (triangle) ramp and the sweep_dn output.
module dds_sweep_ctrl
    import dds_pkg::*;
#(
    parameter int unsigned W       = DDS_W,
    parameter int unsigned DWELL_W = 16
) (
    input  logic               clk,
    input  logic               reset,
    input  logic               start,
    input  logic               abort,
    input  logic [W-1:0]       cfg_start_step,
    input  logic [W-1:0]       cfg_stop_step,
    input  logic [W-1:0]       cfg_inc,
    input  logic [DWELL_W-1:0] cfg_dwell,
    input  logic               cfg_cont,
    output logic [W-1:0]       step_out,
    output logic               acc_clear,
    output logic               busy,
`ifdef DDS_SWEEP_TRIANGLE_EN
    output logic               sweep_dn,
`endif
    output logic               done
);

    sweep_state_t       state_q, state_d;
    logic [W-1:0]       step_q, step_d;
    logic               acc_clear_q, acc_clear_d;
    logic               busy_q, busy_d;
    logic               done_q, done_d;

    logic [W-1:0]       start_sh_q, start_sh_d;
    logic [W-1:0]       stop_sh_q, stop_sh_d;
    logic [W-1:0]       inc_sh_q, inc_sh_d;
    logic [DWELL_W-1:0] dwell_sh_q, dwell_sh_d;
    logic               cont_sh_q, cont_sh_d;

    logic               tmr_load, tmr_run, tmr_expire;

    logic [W:0]         up_sum;
    logic               up_ok;
    sweep_state_t       ramp_state;
    logic [W-1:0]       ramp_step;

`ifdef DDS_SWEEP_TRIANGLE_EN
    logic               dn_q, dn_d;
    logic [W:0]         dn_diff;
    logic               dn_ok;
    logic               ramp_dn;
`endif

    dds_dwell_timer #(
        .DWELL_W (DWELL_W)
    ) u_dwell_timer (
        .clk      (clk),
        .reset    (reset),
        .load_i   (tmr_load),
        .run_i    (tmr_run),
        .dwell_i  (dwell_sh_q),
        .expire_o (tmr_expire)
    );

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q     <= IDLE;
            step_q      <= '0;
            acc_clear_q <= 1'b0;
            busy_q      <= 1'b0;
            done_q      <= 1'b0;
            start_sh_q  <= '0;
            stop_sh_q   <= '0;
            inc_sh_q    <= '0;
            dwell_sh_q  <= '0;
            cont_sh_q   <= 1'b0;
`ifdef DDS_SWEEP_TRIANGLE_EN
            dn_q        <= 1'b0;
`endif
        end else begin
            state_q     <= state_d;
            step_q      <= step_d;
            acc_clear_q <= acc_clear_d;
            busy_q      <= busy_d;
            done_q      <= done_d;
            start_sh_q  <= start_sh_d;
            stop_sh_q   <= stop_sh_d;
            inc_sh_q    <= inc_sh_d;
            dwell_sh_q  <= dwell_sh_d;
            cont_sh_q   <= cont_sh_d;
`ifdef DDS_SWEEP_TRIANGLE_EN
            dn_q        <= dn_d;
`endif
        end
    end

    // Step arithmetic is one bit wider so a carry/borrow out ends the ramp instead of wrapping.
    always_comb begin
        up_sum = {1'b0, step_q} + {1'b0, inc_sh_q};
        up_ok  = (inc_sh_q != '0) && (step_q < stop_sh_q) && (up_sum <= {1'b0, stop_sh_q});
`ifdef DDS_SWEEP_TRIANGLE_EN
        dn_diff = {1'b0, step_q} - {1'b0, inc_sh_q};
        dn_ok   = (inc_sh_q != '0) && !dn_diff[W] && (dn_diff[W-1:0] >= start_sh_q);
`endif
    end

    // Decision taken when the current step's dwell expires.
    always_comb begin
        ramp_state = DONE;
        ramp_step  = step_q;
`ifdef DDS_SWEEP_TRIANGLE_EN
        ramp_dn    = 1'b0;
        if (!dn_q) begin
            if (up_ok) begin
                ramp_state = STEP;
                ramp_step  = up_sum[W-1:0];
            end else if (dn_ok) begin
                ramp_state = STEP;
                ramp_step  = dn_diff[W-1:0];
                ramp_dn    = 1'b1;
            end else if (cont_sh_q) begin
                ramp_state = DWELL;
            end
        end else begin
            if (dn_ok) begin
                ramp_state = STEP;
                ramp_step  = dn_diff[W-1:0];
                ramp_dn    = 1'b1;
            end else if (cont_sh_q && up_ok) begin
                ramp_state = STEP;
                ramp_step  = up_sum[W-1:0];
            end else if (cont_sh_q) begin
                ramp_state = DWELL;
            end
        end
`else
        if (up_ok) begin
            ramp_state = STEP;
            ramp_step  = up_sum[W-1:0];
        end else if (cont_sh_q) begin
            ramp_state = DWELL;
            ramp_step  = start_sh_q;
        end
`endif
    end

    always_comb begin
        state_d     = state_q;
        step_d      = step_q;
        acc_clear_d = 1'b0;
        busy_d      = busy_q;
        done_d      = 1'b0;
        start_sh_d  = start_sh_q;
        stop_sh_d   = stop_sh_q;
        inc_sh_d    = inc_sh_q;
        dwell_sh_d  = dwell_sh_q;
        cont_sh_d   = cont_sh_q;
        tmr_load    = 1'b0;
        tmr_run     = 1'b0;
`ifdef DDS_SWEEP_TRIANGLE_EN
        dn_d        = dn_q;
`endif

        unique case (state_q)
            IDLE: begin
                tmr_load = 1'b1;
                if (start && !abort) begin
                    start_sh_d  = cfg_start_step;
                    stop_sh_d   = cfg_stop_step;
                    inc_sh_d    = cfg_inc;
                    dwell_sh_d  = cfg_dwell;
                    cont_sh_d   = cfg_cont;
                    state_d     = CLEAR;
                    acc_clear_d = 1'b1;
                    busy_d      = 1'b1;
                end
            end
            CLEAR: begin
                step_d   = start_sh_q;
                state_d  = DWELL;
                tmr_load = 1'b1;
`ifdef DDS_SWEEP_TRIANGLE_EN
                dn_d     = 1'b0;
`endif
            end
            DWELL, STEP: begin
                if (tmr_expire) begin
                    state_d = ramp_state;
                    step_d  = ramp_step;
`ifdef DDS_SWEEP_TRIANGLE_EN
                    dn_d    = ramp_dn;
`endif
                    if (ramp_state == DONE) begin
                        done_d = 1'b1;
                    end else begin
                        tmr_load = 1'b1;
                    end
                end else begin
                    state_d = DWELL;
                    tmr_run = 1'b1;
                end
            end
            DONE: begin
                state_d  = IDLE;
                busy_d   = 1'b0;
                tmr_load = 1'b1;
            end
            default: begin
                state_d  = IDLE;
                busy_d   = 1'b0;
                tmr_load = 1'b1;
            end
        endcase

        // Abort overrides everything, including a same-cycle start.
        if (abort) begin
            state_d     = IDLE;
            step_d      = '0;
            acc_clear_d = 1'b0;
            busy_d      = 1'b0;
            done_d      = 1'b0;
            tmr_load    = 1'b1;
            tmr_run     = 1'b0;
`ifdef DDS_SWEEP_TRIANGLE_EN
            dn_d        = 1'b0;
`endif
        end
    end

    assign step_out  = step_q;
    assign acc_clear = acc_clear_q;
    assign busy      = busy_q;
    assign done      = done_q;
`ifdef DDS_SWEEP_TRIANGLE_EN
    assign sweep_dn  = dn_q;
`endif

endmodule

// File: tb/tb_dds_sweep_ctrl.sv
// Directed self-checking bench for dds_sweep_ctrl; outputs sampled on the falling edge.
module tb_dds_sweep_ctrl;

    localparam int unsigned W  = 12;
    localparam int unsigned DW = 16;

    logic          clk = 1'b0;
    logic          reset;
    logic          start;
    logic          abort;
    logic [W-1:0]  cfg_start_step;
    logic [W-1:0]  cfg_stop_step;
    logic [W-1:0]  cfg_inc;
    logic [DW-1:0] cfg_dwell;
    logic          cfg_cont;
    logic [W-1:0]  step_out;
    logic          acc_clear;
    logic          busy;
    logic          done;
`ifdef DDS_SWEEP_TRIANGLE_EN
    logic          sweep_dn;
`endif

    int n_chk  = 0;
    int n_fail = 0;

    always #5 clk = ~clk;

    dds_sweep_ctrl #(
        .W       (W),
        .DWELL_W (DW)
    ) dut (
        .clk            (clk),
        .reset          (reset),
        .start          (start),
        .abort          (abort),
        .cfg_start_step (cfg_start_step),
        .cfg_stop_step  (cfg_stop_step),
        .cfg_inc        (cfg_inc),
        .cfg_dwell      (cfg_dwell),
        .cfg_cont       (cfg_cont),
        .step_out       (step_out),
        .acc_clear      (acc_clear),
        .busy           (busy),
`ifdef DDS_SWEEP_TRIANGLE_EN
        .sweep_dn       (sweep_dn),
`endif
        .done           (done)
    );

    task automatic chk(input string tag, input logic [W-1:0] obs, input logic [W-1:0] exp);
        n_chk++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic chk_out(input string tag, input logic [W-1:0] s, input logic ac,
                           input logic b, input logic d);
        chk({tag, ".step"}, step_out, s);
        chk({tag, ".acc_clear"}, W'(acc_clear), W'(ac));
        chk({tag, ".busy"}, W'(busy), W'(b));
        chk({tag, ".done"}, W'(done), W'(d));
    endtask

    task automatic tick();
        @(negedge clk);
    endtask

    task automatic set_cfg(input logic [W-1:0] s, input logic [W-1:0] p, input logic [W-1:0] i,
                           input logic [DW-1:0] dw, input logic c);
        cfg_start_step = s;
        cfg_stop_step  = p;
        cfg_inc        = i;
        cfg_dwell      = dw;
        cfg_cont       = c;
    endtask

    // Request a sweep; returns sampling the CLEAR cycle.
    task automatic pulse_start(input string tag);
        start = 1'b1;
        tick();
        start = 1'b0;
        chk({tag, ".clr.acc_clear"}, W'(acc_clear), W'(1'b1));
        chk({tag, ".clr.busy"}, W'(busy), W'(1'b1));
    endtask

    logic [W-1:0] seq[$];
    logic [W-1:0] last;

    initial begin
        reset = 1'b0;
        start = 1'b0;
        abort = 1'b0;
        set_cfg('0, '0, '0, '0, 1'b0);

        // Reset values
        tick();
        tick();
        chk_out("reset", '0, 1'b0, 1'b0, 1'b0);
        reset = 1'b1;
        tick();
        chk_out("post_reset", '0, 1'b0, 1'b0, 1'b0);

        // Basic single sweep, cfg changed after latch, start while busy ignored
        set_cfg(12'h020, 12'h040, 12'h010, 16'd3, 1'b0);
        pulse_start("saw");
        chk("saw.clr.step", step_out, 12'h000);
        set_cfg(12'h000, 12'hFFF, 12'h001, 16'd0, 1'b1);
`ifdef DDS_SWEEP_TRIANGLE_EN
        seq = '{12'h020, 12'h030, 12'h040, 12'h030, 12'h020};
`else
        seq = '{12'h020, 12'h030, 12'h040};
`endif
        foreach (seq[i]) begin
            for (int k = 0; k < 4; k++) begin
                tick();
                chk_out($sformatf("saw.s%0d.c%0d", i, k), seq[i], 1'b0, 1'b1, 1'b0);
                start = (i == 0 && k == 1);
            end
        end
        start = 1'b0;
        last = seq[seq.size()-1];
        tick();
        chk_out("saw.done", last, 1'b0, 1'b1, 1'b1);
        tick();
        chk_out("saw.idle", last, 1'b0, 1'b0, 1'b0);

        // Carry-out at top of range ends ramp without wrapping
        set_cfg(12'hFF0, 12'hFF8, 12'h010, 16'd1, 1'b0);
        pulse_start("carry");
        for (int k = 0; k < 2; k++) begin
            tick();
            chk_out($sformatf("carry.c%0d", k), 12'hFF0, 1'b0, 1'b1, 1'b0);
        end
        tick();
        chk_out("carry.done", 12'hFF0, 1'b0, 1'b1, 1'b1);
        tick();
        chk_out("carry.idle", 12'hFF0, 1'b0, 1'b0, 1'b0);

        // Continuous sweep with dwell 0, then abort
        set_cfg(12'h100, 12'h300, 12'h100, 16'd0, 1'b1);
        pulse_start("cont");
`ifdef DDS_SWEEP_TRIANGLE_EN
        seq = '{12'h100, 12'h200, 12'h300, 12'h200, 12'h100, 12'h200, 12'h300};
`else
        seq = '{12'h100, 12'h200, 12'h300, 12'h100, 12'h200, 12'h300, 12'h100};
`endif
        foreach (seq[i]) begin
            tick();
            chk_out($sformatf("cont.s%0d", i), seq[i], 1'b0, 1'b1, 1'b0);
        end
        abort = 1'b1;
        tick();
        abort = 1'b0;
        chk_out("cont.abort", '0, 1'b0, 1'b0, 1'b0);
        tick();
        chk_out("cont.abort2", '0, 1'b0, 1'b0, 1'b0);

        // start and abort in the same cycle: abort wins
        set_cfg(12'h010, 12'h020, 12'h010, 16'd0, 1'b0);
        start = 1'b1;
        abort = 1'b1;
        tick();
        start = 1'b0;
        abort = 1'b0;
        chk_out("st_ab", '0, 1'b0, 1'b0, 1'b0);
        tick();
        chk_out("st_ab2", '0, 1'b0, 1'b0, 1'b0);

        // start_step above stop: one dwell at start_step
        set_cfg(12'h050, 12'h040, 12'h010, 16'd0, 1'b0);
        pulse_start("inv");
        tick();
        chk_out("inv.s0", 12'h050, 1'b0, 1'b1, 1'b0);
        tick();
        chk_out("inv.done", 12'h050, 1'b0, 1'b1, 1'b1);
        tick();
        chk_out("inv.idle", 12'h050, 1'b0, 1'b0, 1'b0);

        // Zero increment: single dwell then done
        set_cfg(12'h123, 12'h200, 12'h000, 16'd2, 1'b0);
        pulse_start("inc0");
        for (int k = 0; k < 3; k++) begin
            tick();
            chk_out($sformatf("inc0.c%0d", k), 12'h123, 1'b0, 1'b1, 1'b0);
        end
        tick();
        chk_out("inc0.done", 12'h123, 1'b0, 1'b1, 1'b1);
        tick();
        chk_out("inc0.idle", 12'h123, 1'b0, 1'b0, 1'b0);

        // Asynchronous reset mid-sweep
        set_cfg(12'h020, 12'h040, 12'h010, 16'd3, 1'b0);
        pulse_start("areset");
        tick();
        tick();
        chk_out("areset.run", 12'h020, 1'b0, 1'b1, 1'b0);
        #2 reset = 1'b0;
        #1 chk_out("areset.async", '0, 1'b0, 1'b0, 1'b0);
        tick();
        reset = 1'b1;
        tick();
        chk_out("areset.after", '0, 1'b0, 1'b0, 1'b0);

`ifdef DDS_SWEEP_TRIANGLE_EN
        // Triangle up/down ramp
        set_cfg(12'h010, 12'h030, 12'h010, 16'd1, 1'b0);
        pulse_start("tri");
        seq = '{12'h010, 12'h010, 12'h020, 12'h020, 12'h030, 12'h030,
                12'h020, 12'h020, 12'h010, 12'h010};
        foreach (seq[i]) begin
            tick();
            chk_out($sformatf("tri.c%0d", i), seq[i], 1'b0, 1'b1, 1'b0);
            chk($sformatf("tri.c%0d.dn", i), W'(sweep_dn), W'(i >= 6));
        end
        tick();
        chk_out("tri.done", 12'h010, 1'b0, 1'b1, 1'b1);
        chk("tri.done.dn", W'(sweep_dn), W'(1'b0));
`endif

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
